sgi_irq_ctrl: RTL and testbench
===============================

# sgi_irq_ctrl

Per-tile interrupt controller between the tile's special-function register block and the CPU core. It latches software-generated interrupts (SGI, raised by an MSI write into the tile SFR space) and rising edges on external IRQ lines into a pending vector. It applies an enable mask, picks the lowest-numbered enabled pending source, and presents it to the core through a request/acknowledge/end-of-interrupt handshake. Only one interrupt is in service at a time.

## Interface
- IRQ_NUM_POW, 4, log2 of source count; IRQ_NUM = 2**IRQ_NUM_POW sources, codes 0..IRQ_NUM-1
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- sgi_req_i  in  1  single-cycle SGI strobe from the SFR block
- sgi_code_bi  in  IRQ_NUM_POW  SGI source number, valid with sgi_req_i
- irq_bi  in  IRQ_NUM  external interrupt levels, synchronous to clk_i; rising edge = event
- mask_we_i  in  1  mask write strobe
- mask_wdata_bi  in  IRQ_NUM  new mask value; bit=1 enables the source
- mask_bo  out  IRQ_NUM  current mask register
- pending_bo  out  IRQ_NUM  current pending register, unmasked view
- irq_req_o  out  1  interrupt request to core
- irq_code_bo  out  IRQ_NUM_POW  number of the requested/in-service source
- irq_ack_i  in  1  core accepts the request
- irq_eoi_i  in  1  core finished the handler (end of interrupt)
- busy_o  out  1  1 in REQ or SERVICE

## Operation
- Registers: pending[IRQ_NUM], mask[IRQ_NUM], irq_prev[IRQ_NUM] (previous irq_bi sample), state, irq_code_bo.
- Event vector per cycle: ev = (irq_bi & ~irq_prev), ORed with the one-hot of sgi_code_bi when sgi_req_i=1.
- Pending update: pending <= (pending & ~clr) | ev. clr is the one-hot of irq_code_bo when the REQ->SERVICE transition fires, else 0. Set wins over clear on the same bit.
- Events on masked sources still set pending. Mask only gates selection.
- Mask write: mask <= mask_wdata_bi on mask_we_i. It takes effect for selection from the next cycle.
- Selection: cand = pending & mask. The winner is the lowest set index of cand. This is fixed priority; no round-robin.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if cand != 0, then irq_code_bo <= winner and go to REQ. Otherwise stay.
  - REQ: irq_req_o=1. irq_code_bo stays frozen. On irq_ack_i=1, clear pending[irq_code_bo] and go to SERVICE. The request is never retracted, even if the source is masked meanwhile.
  - SERVICE: irq_req_o=0. irq_code_bo still shows the in-service code. On irq_eoi_i=1, go to IDLE.
- Ignored inputs:
  - irq_ack_i outside REQ is ignored.
  - irq_eoi_i outside SERVICE is ignored.
  - ack and eoi asserted together in REQ: only the ack is taken; eoi is ignored.
- Nesting: none. A re-event of the in-service source during SERVICE sets pending again and is delivered after EOI.
- Outputs: busy_o = (state != IDLE). mask_bo and pending_bo are direct register outputs.

## Timing
- Reset (async assert, synchronous deassert by the system) forces:
  - pending=0, mask=0 (all disabled), irq_prev=0, state=IDLE, irq_code_bo=0.
  - irq_req_o=0, busy_o=0.
- irq_prev resets to 0. An irq_bi line already high at reset release counts as one event.
- Reset mid-handshake drops the request and all pending events immediately. There is no replay.
- Latency:
  - An event sampled at edge N sets pending at edge N.
  - The FSM enters REQ at edge N+1, so irq_req_o is high in the cycle after N+1.
  - This gives 2 cycles from the strobe cycle to request.
- Ack accepted at edge A: irq_req_o is low after A and the pending bit is cleared at A.
- After EOI accepted at edge E, the next request can appear after edge E+1.
- irq_req_o and irq_code_bo are registered and glitch-free. irq_code_bo is stable throughout REQ and SERVICE.
- Simultaneous SGI and external edge on different sources: both set pending in the same cycle.

## Test plan
- SGI delivery:
  - Stimulus: mask=16'hFFFF; sgi_req_i pulse with code 5.
  - Response: pending_bo=16'h0020 one cycle later; irq_req_o=1, irq_code_bo=5 one cycle after that.
  - Ack -> pending_bo=0, busy_o=1. EOI -> busy_o=0.
- Priority:
  - Stimulus: mask=16'hFFFF; irq_bi bits 3 and 9 rise together.
  - Response: code 3 is served first. After EOI, code 9 is requested; pending_bo=16'h0200 during service of 3.
- Masking:
  - Stimulus: mask=0; SGI code 2.
  - Response: pending_bo=16'h0004, irq_req_o stays 0.
  - Then write mask=16'h0004 -> irq_req_o=1, code 2, two cycles after the write.
- Edge detection:
  - Stimulus: hold irq_bi[7]=1 for 10 cycles; ack and EOI.
  - Response: exactly one delivery of code 7. Dropping and re-raising the line produces a second delivery.
- Set/clear collision:
  - Stimulus: SGI code 4 in the same cycle as irq_ack_i for in-flight code 4.
  - Response: pending_bo[4]=1 after that edge; code 4 is redelivered after EOI.
- Async reset:
  - Stimulus: assert rst_i mid-cycle while in SERVICE with pending=16'h0101.
  - Response: immediately irq_req_o=0, busy_o=0, pending_bo=0, mask_bo=0, irq_code_bo=0.

Source files
------------

// File: rtl/sgi_irq_ctrl.sv
// Per-tile interrupt controller: latches SGI strobes and external IRQ rising
// edges into a pending vector, applies an enable mask and presents the
// lowest-numbered enabled source to the core via req/ack/eoi.
module sgi_irq_ctrl #(
  parameter int unsigned IRQ_NUM_POW = 4,
  localparam int unsigned IRQ_NUM = 2 ** IRQ_NUM_POW
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sgi_req_i,
  input  logic [IRQ_NUM_POW-1:0] sgi_code_bi,
  input  logic [IRQ_NUM-1:0]     irq_bi,
  input  logic                   mask_we_i,
  input  logic [IRQ_NUM-1:0]     mask_wdata_bi,
  output logic [IRQ_NUM-1:0]     mask_bo,
  output logic [IRQ_NUM-1:0]     pending_bo,
  output logic                   irq_req_o,
  output logic [IRQ_NUM_POW-1:0] irq_code_bo,
  input  logic                   irq_ack_i,
  input  logic                   irq_eoi_i,
  output logic                   busy_o
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e                 state_q, state_d;
  logic [IRQ_NUM-1:0]     pending_q, pending_d;
  logic [IRQ_NUM-1:0]     mask_q, mask_d;
  logic [IRQ_NUM-1:0]     irq_prev_q;
  logic [IRQ_NUM_POW-1:0] code_q, code_d;
  logic                   req_q, req_d;

  logic [IRQ_NUM-1:0]     ev;
  logic [IRQ_NUM-1:0]     clr;
  logic [IRQ_NUM-1:0]     cand;
  logic [IRQ_NUM_POW-1:0] winner;

  // Event detection, pending/mask next state and fixed-priority selection
  always_comb begin
    ev = irq_bi & ~irq_prev_q;
    if (sgi_req_i) begin
      ev = ev | (IRQ_NUM'(1) << sgi_code_bi);
    end
    // Set wins over clear on the same bit
    pending_d = (pending_q & ~clr) | ev;
    mask_d    = mask_we_i ? mask_wdata_bi : mask_q;
    cand      = pending_q & mask_q;
    winner    = '0;
    // Scan downwards so the lowest set index is written last
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (cand[i]) begin
        winner = IRQ_NUM_POW'(i);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; ack has priority over eoi while in REQ
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (|cand)     state_d = StReq;
      StReq:     if (irq_ack_i) state_d = StService;
      StService: if (irq_eoi_i) state_d = StIdle;
      default:                  state_d = StIdle;
    endcase
  end

  // FSM outputs: code capture, pending clear on accept, registered request
  always_comb begin
    code_d = code_q;
    clr    = '0;
    case (state_q)
      StIdle:  if (|cand)     code_d = winner;
      StReq:   if (irq_ack_i) clr = IRQ_NUM'(1) << code_q;
      default: ;
    endcase
    req_d  = (state_d == StReq);
    busy_o = (state_q != StIdle);
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q  <= '0;
      mask_q     <= '0;
      irq_prev_q <= '0;
      code_q     <= '0;
      req_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      irq_prev_q <= irq_bi;
      code_q     <= code_d;
      req_q      <= req_d;
    end
  end

  assign mask_bo     = mask_q;
  assign pending_bo  = pending_q;
  assign irq_req_o   = req_q;
  assign irq_code_bo = code_q;

endmodule

// File: tb/tb_sgi_irq_ctrl.sv
// Directed bench for sgi_irq_ctrl with hand-computed expectations.
module tb_sgi_irq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        sgi_req_i;
  logic [3:0]  sgi_code_bi;
  logic [15:0] irq_bi;
  logic        mask_we_i;
  logic [15:0] mask_wdata_bi;
  logic [15:0] mask_bo;
  logic [15:0] pending_bo;
  logic        irq_req_o;
  logic [3:0]  irq_code_bo;
  logic        irq_ack_i;
  logic        irq_eoi_i;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  sgi_irq_ctrl #(.IRQ_NUM_POW(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .sgi_req_i    (sgi_req_i),
    .sgi_code_bi  (sgi_code_bi),
    .irq_bi       (irq_bi),
    .mask_we_i    (mask_we_i),
    .mask_wdata_bi(mask_wdata_bi),
    .mask_bo      (mask_bo),
    .pending_bo   (pending_bo),
    .irq_req_o    (irq_req_o),
    .irq_code_bo  (irq_code_bo),
    .irq_ack_i    (irq_ack_i),
    .irq_eoi_i    (irq_eoi_i),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic write_mask(input logic [15:0] m);
    mask_we_i = 1'b1; mask_wdata_bi = m;
    step();
    mask_we_i = 1'b0;
  endtask

  task automatic sgi(input logic [3:0] c);
    sgi_req_i = 1'b1; sgi_code_bi = c;
    step();
    sgi_req_i = 1'b0;
  endtask

  task automatic ack();
    irq_ack_i = 1'b1;
    step();
    irq_ack_i = 1'b0;
  endtask

  task automatic eoi();
    irq_eoi_i = 1'b1;
    step();
    irq_eoi_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; sgi_req_i = 0; sgi_code_bi = 0; irq_bi = 0;
    mask_we_i = 0; mask_wdata_bi = 0; irq_ack_i = 0; irq_eoi_i = 0;
    step(); step();
    check("rst_req", irq_req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_pending", pending_bo, 0);
    check("rst_mask", mask_bo, 0);
    check("rst_code", irq_code_bo, 0);
    rst_i = 1'b0;
    step();

    // SGI delivery
    write_mask(16'hFFFF);
    check("mask_write", mask_bo, 16'hFFFF);
    sgi(4'd5);
    check("sgi_pending", pending_bo, 16'h0020);
    check("sgi_req_early", irq_req_o, 0);
    step();
    check("sgi_req", irq_req_o, 1);
    check("sgi_code", irq_code_bo, 5);
    ack();
    check("sgi_ack_pending", pending_bo, 0);
    check("sgi_ack_req", irq_req_o, 0);
    check("sgi_ack_busy", busy_o, 1);
    check("sgi_svc_code", irq_code_bo, 5);
    eoi();
    check("sgi_eoi_busy", busy_o, 0);

    // Priority
    irq_bi = 16'h0208;
    step();
    check("prio_pending", pending_bo, 16'h0208);
    step();
    check("prio_req3", irq_req_o, 1);
    check("prio_code3", irq_code_bo, 3);
    ack();
    check("prio_pending_svc3", pending_bo, 16'h0200);
    eoi();
    check("prio_idle", busy_o, 0);
    step();
    check("prio_req9", irq_req_o, 1);
    check("prio_code9", irq_code_bo, 9);
    ack(); eoi();
    irq_bi = 16'h0000;
    step();
    check("prio_done", pending_bo, 0);

    // Masking
    write_mask(16'h0000);
    sgi(4'd2);
    check("mask_pending", pending_bo, 16'h0004);
    step(); step();
    check("mask_noreq", irq_req_o, 0);
    write_mask(16'h0004);
    check("mask_req_w1", irq_req_o, 0);
    step();
    check("mask_req_w2", irq_req_o, 1);
    check("mask_code", irq_code_bo, 2);
    ack(); eoi();
    write_mask(16'hFFFF);

    // Edge detection: line held high for 10 cycles yields one delivery
    irq_bi = 16'h0080;
    step();
    step();
    check("edge_req", irq_req_o, 1);
    check("edge_code", irq_code_bo, 7);
    ack(); eoi();
    for (int i = 0; i < 6; i++) step();
    check("edge_once_req", irq_req_o, 0);
    check("edge_once_busy", busy_o, 0);
    check("edge_once_pend", pending_bo, 0);
    irq_bi = 16'h0000;
    step();
    irq_bi = 16'h0080;
    step();
    step();
    check("edge_re_req", irq_req_o, 1);
    check("edge_re_code", irq_code_bo, 7);
    ack(); eoi();
    irq_bi = 16'h0000;
    step();

    // Set/clear collision; then ack+eoi together takes only the ack
    sgi(4'd4);
    step();
    check("coll_req", irq_code_bo, 4);
    irq_ack_i = 1'b1; sgi_req_i = 1'b1; sgi_code_bi = 4'd4;
    step();
    irq_ack_i = 1'b0; sgi_req_i = 1'b0;
    check("coll_pending", pending_bo, 16'h0010);
    check("coll_busy", busy_o, 1);
    eoi();
    step();
    check("coll_redeliver", irq_req_o, 1);
    check("coll_code", irq_code_bo, 4);
    irq_ack_i = 1'b1; irq_eoi_i = 1'b1;
    step();
    irq_ack_i = 1'b0; irq_eoi_i = 1'b0;
    check("ackeoi_busy", busy_o, 1);
    check("ackeoi_req", irq_req_o, 0);
    eoi();
    check("ackeoi_idle", busy_o, 0);

    // Async reset in SERVICE with pending 0x0101
    irq_bi = 16'h0101;
    step();
    step();
    check("rst2_code", irq_code_bo, 0);
    ack();
    sgi(4'd0);
    check("rst2_pre_pending", pending_bo, 16'h0101);
    check("rst2_pre_busy", busy_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check("arst_req", irq_req_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_pending", pending_bo, 0);
    check("arst_mask", mask_bo, 0);
    check("arst_code", irq_code_bo, 0);
    step();
    rst_i = 1'b0;
    // Line already high at reset release counts as one event
    step();
    check("release_event", pending_bo, 16'h0101);
    step();
    check("release_masked", irq_req_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
